if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clk.
REQ-002 The block SHALL provide port clk, input, 1 bit: system clock.
REQ-003 The block SHALL provide port reset, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL provide port Stall, input, 1 bit: load-use stall request from hazard detection.
REQ-005 The block SHALL provide port Flush, input, 1 bit: branch/jump/jump-register redirect request from hazard detection.
REQ-006 The block SHALL provide port Target_Addr, input, 32 bits: redirect address, valid when Flush=1.
REQ-007 The block SHALL provide port Inst_In, input, 32 bits: instruction memory read data for the current PC_Out.
REQ-008 The block SHALL provide port PC_Out, output, 32 bits: fetch address to instruction memory.
REQ-009 The block SHALL provide port IFID_IR, output, 32 bits: IF/ID instruction register.
REQ-010 The block SHALL provide port IFID_PC4, output, 32 bits: IF/ID PC+4 of the held instruction.
REQ-011 The block SHALL provide port IFID_Valid, output, 1 bit: IFID_IR holds a real (non-bubble) instruction.
REQ-012 The block SHALL provide port Bubble, output, 1 bit, combinational: the ID/EX register loads an all-zero control word at the next edge.
REQ-013 The block SHALL provide port Stall_Cnt, output, 8 bits: saturating count of stall cycles.
REQ-014 The block SHALL provide port Flush_Cnt, output, 8 bits: saturating count of flush cycles.

Function
REQ-015 The block SHALL evaluate one of three cycle modes per clock, in priority order: FLUSH (Flush=1), STALL (Flush=0, Stall=1), RUN (both 0).
REQ-016 In FLUSH mode, the block SHALL load PC_Out with {Target_Addr[31:2],2'b00} at the edge, with the low two bits forced to zero.
REQ-017 In FLUSH mode, the block SHALL load IFID_IR with 32'h0000_0000 (NOP), clear IFID_Valid, and load IFID_PC4 with 0.
REQ-018 In STALL mode, the block SHALL hold PC_Out, IFID_IR, IFID_PC4 and IFID_Valid unchanged.
REQ-019 In RUN mode, the block SHALL load PC_Out with PC_Out+4, IFID_IR with Inst_In, IFID_PC4 with PC_Out+4, and set IFID_Valid to 1.
REQ-020 PC+4 arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC advances to 32'h0000_0000 with no error flag.
REQ-021 Bubble SHALL equal Stall OR Flush combinationally in the same cycle; its value SHALL be identical for Stall=1 alone, Flush=1 alone, and both asserted.
REQ-022 When Stall=1 and Flush=1 together, the block SHALL execute FLUSH mode, SHALL increment Flush_Cnt, and SHALL NOT increment Stall_Cnt.
REQ-023 Stall_Cnt SHALL increment by 1 on each STALL-mode edge and SHALL saturate at 8'hFF.
REQ-024 Flush_Cnt SHALL increment by 1 on each FLUSH-mode edge and SHALL saturate at 8'hFF.
REQ-025 Consecutive STALL cycles SHALL be unlimited; the held state SHALL persist for any number of cycles.
REQ-026 On the first RUN cycle after a stall, the block SHALL capture Inst_In for the held PC_Out.
REQ-027 A FLUSH cycle immediately following a STALL cycle SHALL discard the held instruction and SHALL redirect per REQ-016/REQ-017.
REQ-028 Latency from Target_Addr to PC_Out SHALL be one clock; the redirected instruction SHALL appear in IFID_IR one RUN cycle later.

Reset
REQ-029 When reset=1 at an edge, the block SHALL set PC_Out, IFID_IR, IFID_PC4, Stall_Cnt and Flush_Cnt to 0 and clear IFID_Valid, ignoring Stall and Flush.
REQ-030 Reset asserted mid-stall or mid-flush SHALL take priority over both; the first post-reset RUN edge SHALL fetch from address 0.
REQ-031 Bubble SHALL remain combinational and SHALL NOT be gated by reset.

Verification
REQ-032 Reset, then 3 RUN cycles with Inst_In=A,B,C -> PC_Out=4,8,12; IFID_IR=A,B,C; IFID_PC4=4,8,12; IFID_Valid=1.
REQ-033 At PC_Out=8, hold Stall=1 for 2 cycles -> PC_Out stays 8, IFID_IR holds, Bubble=1 both cycles, Stall_Cnt=2; next RUN edge -> PC_Out=12.
REQ-034 At PC_Out=12, apply Flush=1, Target_Addr=32'h0000_0103 -> PC_Out=32'h0000_0100, IFID_IR=0, IFID_Valid=0, Flush_Cnt=1.
REQ-035 Apply Stall=1 and Flush=1 together with Target_Addr=32'h40 -> PC_Out=32'h40, Flush_Cnt increments, Stall_Cnt unchanged.
REQ-036 Apply 260 consecutive stall cycles -> Stall_Cnt=8'hFF; at PC_Out=32'hFFFF_FFFC, one RUN edge -> PC_Out=0.
REQ-037 Assert reset during a stall with Stall_Cnt=5 -> all registered outputs=0 on the next edge; Bubble still follows Stall.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: owns the fetch PC and the IF/ID instruction register,
// applying redirect (flush), hold (stall) or advance (run) once per clock.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [31:0] Target_Addr,
  input  logic [31:0] Inst_In,
  output logic [31:0] PC_Out,
  output logic [31:0] IFID_IR,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid,
  output logic        Bubble,
  output logic [7:0]  Stall_Cnt,
  output logic [7:0]  Flush_Cnt
);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_STALL = 2'd1,
    MODE_FLUSH = 2'd2
  } mode_e;

  mode_e       mode;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [7:0]  stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_plus4;

  // Flush outranks stall: a redirect discards whatever the stall was holding.
  always_comb begin
    mode = MODE_RUN;
    if (Flush)      mode = MODE_FLUSH;
    else if (Stall) mode = MODE_STALL;
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (mode)
      MODE_FLUSH: begin
        pc_d    = {Target_Addr[31:2], 2'b00};
        ir_d    = 32'h0000_0000;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
        if (flush_cnt_q != 8'hFF) flush_cnt_d = flush_cnt_q + 8'd1;
      end
      MODE_STALL: begin
        if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
      end
      default: begin
        pc_d    = pc_plus4;
        ir_d    = Inst_In;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= 32'h0000_0000;
      ir_q        <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      stall_cnt_q <= 8'h00;
      flush_cnt_q <= 8'h00;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Bubble is deliberately independent of reset so ID/EX sees it immediately.
  assign Bubble     = Stall | Flush;
  assign PC_Out     = pc_q;
  assign IFID_IR    = ir_q;
  assign IFID_PC4   = pc4_q;
  assign IFID_Valid = valid_q;
  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;

endmodule
